// File: rtl/my_pll_pkg.sv
// Shared constants and sizing helper for the my_pll_core clock generator.
// Latency: n/a (package only). Backpressure: none.
package my_pll_pkg;

    localparam int PLL_DEF_CLK_DIV     = 1;
    localparam int PLL_DEF_LOCK_CYCLES = 16;
    localparam int PLL_PARAM_MAX       = 65535;

    // Width of a counter that must hold 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/my_pll_lock_det.sv
// Saturating lock counter with a sticky locked flag, cleared only by reset.
// Latency: locked rises on the LOCK_CYCLES-th inclk0 posedge after release. Backpressure: none.
module my_pll_lock_det
    import my_pll_pkg::*;
#(
    parameter int LOCK_CYCLES = PLL_DEF_LOCK_CYCLES
) (
    input  logic inclk0,
    input  logic areset_n,
    output logic locked
);

    localparam int             LW        = cnt_width(LOCK_CYCLES + 1);
    localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [LW-1:0]  LOCK_MAX  = LW'(LOCK_CYCLES);

    if (LOCK_CYCLES < 1 || LOCK_CYCLES > PLL_PARAM_MAX) begin : g_bad_lock
        $error("my_pll_lock_det: LOCK_CYCLES out of range 1..65535");
    end

    logic [LW-1:0] lock_cnt;

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (lock_cnt < LOCK_MAX) begin
            lock_cnt <= lock_cnt + 1'b1;
            // Flag goes high on the same edge the count reaches its ceiling.
            if (lock_cnt == LOCK_LAST) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/my_pll_core.sv
// Digital PLL stand-in: c0 = inclk0 / CLK_DIV (registered) or gated pass-through at 1; lock after LOCK_CYCLES.
// Latency: c0 rises on the first inclk0 posedge after release. Backpressure: none. Option: MY_PLL_CORE_CLKEN_EN adds c0_en.
module my_pll_core
    import my_pll_pkg::*;
#(
    parameter int CLK_DIV     = PLL_DEF_CLK_DIV,
    parameter int LOCK_CYCLES = PLL_DEF_LOCK_CYCLES
) (
    input  logic inclk0,
    input  logic areset_n,
    output logic c0,
    output logic locked
`ifdef MY_PLL_CORE_CLKEN_EN
    ,
    output logic c0_en
`endif
);

    if (CLK_DIV < 1 || CLK_DIV > PLL_PARAM_MAX) begin : g_bad_div
        $error("my_pll_core: CLK_DIV out of range 1..65535");
    end

    my_pll_lock_det #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_det (
        .inclk0   (inclk0),
        .areset_n (areset_n),
        .locked   (locked)
    );

    if (CLK_DIV == 1) begin : g_pass
        // Reset gating keeps c0 low while areset_n is asserted.
        assign c0 = inclk0 & areset_n;
`ifdef MY_PLL_CORE_CLKEN_EN
        assign c0_en = locked;
`endif
    end else begin : g_div
        localparam int            CW       = cnt_width(CLK_DIV);
        localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
        localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);

        logic [CW-1:0] cnt;

        always_ff @(posedge inclk0 or negedge areset_n) begin
            if (!areset_n) begin
                cnt <= '0;
                c0  <= 1'b0;
            end else begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                c0  <= (cnt < CNT_HALF);
            end
        end

`ifdef MY_PLL_CORE_CLKEN_EN
        // Pulse in the cycle where c0 goes from low to high.
        always_ff @(posedge inclk0 or negedge areset_n) begin
            if (!areset_n) begin
                c0_en <= 1'b0;
            end else begin
                c0_en <= (cnt < CNT_HALF) && !c0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_my_pll_core.sv
// Directed bench for my_pll_core: several parameterisations share one clock and reset.
module tb_my_pll_core;

    logic inclk0;
    logic areset_n;

    logic c0_d4, lk_d4;
    logic c0_d3, lk_d3;
    logic c0_d1, lk_d1;
    logic c0_d2, lk_d2;
    logic c0_d5, lk_d5;
`ifdef MY_PLL_CORE_CLKEN_EN
    logic en_d4, en_d3, en_d1, en_d2, en_d5;
`endif

    int errors = 0;
    int checks = 0;

    my_pll_core #(.CLK_DIV(4), .LOCK_CYCLES(16)) u_d4 (
        .inclk0(inclk0), .areset_n(areset_n), .c0(c0_d4), .locked(lk_d4)
`ifdef MY_PLL_CORE_CLKEN_EN
        , .c0_en(en_d4)
`endif
    );
    my_pll_core #(.CLK_DIV(3), .LOCK_CYCLES(16)) u_d3 (
        .inclk0(inclk0), .areset_n(areset_n), .c0(c0_d3), .locked(lk_d3)
`ifdef MY_PLL_CORE_CLKEN_EN
        , .c0_en(en_d3)
`endif
    );
    my_pll_core #(.CLK_DIV(1), .LOCK_CYCLES(16)) u_d1 (
        .inclk0(inclk0), .areset_n(areset_n), .c0(c0_d1), .locked(lk_d1)
`ifdef MY_PLL_CORE_CLKEN_EN
        , .c0_en(en_d1)
`endif
    );
    my_pll_core #(.CLK_DIV(2), .LOCK_CYCLES(1)) u_d2 (
        .inclk0(inclk0), .areset_n(areset_n), .c0(c0_d2), .locked(lk_d2)
`ifdef MY_PLL_CORE_CLKEN_EN
        , .c0_en(en_d2)
`endif
    );
    my_pll_core #(.CLK_DIV(5), .LOCK_CYCLES(16)) u_d5 (
        .inclk0(inclk0), .areset_n(areset_n), .c0(c0_d5), .locked(lk_d5)
`ifdef MY_PLL_CORE_CLKEN_EN
        , .c0_en(en_d5)
`endif
    );

    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    task automatic do_reset();
        areset_n = 1'b0;
        repeat (3) @(posedge inclk0);
        @(negedge inclk0);
        areset_n = 1'b1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (2) @(posedge inclk0);
        #1;
        checks++;
        if ({c0_d4, c0_d3, c0_d1, c0_d2, c0_d5} !== 5'b0) begin
            errors++;
            $display("FAIL reset_c0: got %b want 00000", {c0_d4, c0_d3, c0_d1, c0_d2, c0_d5});
        end
        checks++;
        if ({lk_d4, lk_d3, lk_d1, lk_d2, lk_d5} !== 5'b0) begin
            errors++;
            $display("FAIL reset_locked: got %b want 00000", {lk_d4, lk_d3, lk_d1, lk_d2, lk_d5});
        end
`ifdef MY_PLL_CORE_CLKEN_EN
        checks++;
        if ({en_d4, en_d3, en_d1, en_d2, en_d5} !== 5'b0) begin
            errors++;
            $display("FAIL reset_c0_en: got %b want 00000", {en_d4, en_d3, en_d1, en_d2, en_d5});
        end
`endif
        @(negedge inclk0);
        areset_n = 1'b1;
    endtask

    task automatic test_div4_lock();
        do_reset();
        for (int k = 1; k <= 220; k++) begin
            @(posedge inclk0);
            #1;
            checks++;
            if (c0_d4 !== (((k - 1) % 4) < 2)) begin
                errors++;
                $display("FAIL div4_c0 edge %0d: got %b want %b", k, c0_d4, (((k - 1) % 4) < 2));
            end
            checks++;
            if (lk_d4 !== (k >= 16)) begin
                errors++;
                $display("FAIL div4_locked edge %0d: got %b want %b", k, lk_d4, (k >= 16));
            end
        end
    endtask

    task automatic test_div3();
        logic exp;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            exp = (((k - 1) % 3) == 0);
            @(posedge inclk0);
            #1;
            checks++;
            if (c0_d3 !== exp) begin
                errors++;
                $display("FAIL div3_c0_pos edge %0d: got %b want %b", k, c0_d3, exp);
            end
            @(negedge inclk0);
            #1;
            checks++;
            if (c0_d3 !== exp) begin
                errors++;
                $display("FAIL div3_c0_mid edge %0d: got %b want %b", k, c0_d3, exp);
            end
        end
    endtask

    task automatic test_div1();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(posedge inclk0);
            #1;
            checks++;
            if (c0_d1 !== 1'b1) begin
                errors++;
                $display("FAIL div1_high edge %0d: got %b want 1", k, c0_d1);
            end
            @(negedge inclk0);
            #1;
            checks++;
            if (c0_d1 !== 1'b0) begin
                errors++;
                $display("FAIL div1_low edge %0d: got %b want 0", k, c0_d1);
            end
        end
        areset_n = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge inclk0);
            #1;
            checks++;
            if (c0_d1 !== 1'b0) begin
                errors++;
                $display("FAIL div1_in_reset edge %0d: got %b want 0", k, c0_d1);
            end
        end
        @(negedge inclk0);
        areset_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (17) @(posedge inclk0);
        #1;
        checks++;
        if ({c0_d4, lk_d4} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre: got c0,locked=%b want 11", {c0_d4, lk_d4});
        end
        #2;
        areset_n = 1'b0;
        #1;
        checks++;
        if ({c0_d4, lk_d4, c0_d1} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async: got c0,locked,c0_div1=%b want 000", {c0_d4, lk_d4, c0_d1});
        end
        @(negedge inclk0);
        areset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge inclk0);
            #1;
            checks++;
            if ({c0_d4, lk_d4} !== {(((k - 1) % 4) < 2), (k >= 16)}) begin
                errors++;
                $display("FAIL midrst_restart edge %0d: got %b want %b", k, {c0_d4, lk_d4},
                         {(((k - 1) % 4) < 2), (k >= 16)});
            end
        end
    endtask

    task automatic test_lock1_div2();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(posedge inclk0);
            #1;
            checks++;
            if ({c0_d2, lk_d2} !== {((k % 2) == 1), 1'b1}) begin
                errors++;
                $display("FAIL lock1_div2 edge %0d: got c0,locked=%b want %b", k, {c0_d2, lk_d2},
                         {((k % 2) == 1), 1'b1});
            end
        end
    endtask

    task automatic test_clken();
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            @(posedge inclk0);
            #1;
            checks++;
            if (c0_d5 !== (((k - 1) % 5) < 2)) begin
                errors++;
                $display("FAIL div5_c0 edge %0d: got %b want %b", k, c0_d5, (((k - 1) % 5) < 2));
            end
`ifdef MY_PLL_CORE_CLKEN_EN
            checks++;
            if (en_d5 !== (((k - 1) % 5) == 0)) begin
                errors++;
                $display("FAIL div5_c0_en edge %0d: got %b want %b", k, en_d5, (((k - 1) % 5) == 0));
            end
            checks++;
            if (en_d1 !== (k >= 16)) begin
                errors++;
                $display("FAIL div1_c0_en edge %0d: got %b want %b", k, en_d1, (k >= 16));
            end
`endif
        end
    endtask

    initial begin
        areset_n = 1'b0;
        test_reset();
        test_div4_lock();
        test_div3();
        test_div1();
        test_mid_reset();
        test_lock1_div2();
        test_clken();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
